// File: rtl/rp_8bit_tmr_pkg.sv
// Shared constants for the rp_8bit timer: register offsets, bit positions,
// clock-select codes and the clock-select to divisor-minus-one mapping.
package rp_8bit_tmr_pkg;

  localparam logic [2:0] TMR_TCNT  = 3'd0;
  localparam logic [2:0] TMR_OCR   = 3'd1;
  localparam logic [2:0] TMR_TCCR  = 3'd2;
  localparam logic [2:0] TMR_TIFR  = 3'd3;
  localparam logic [2:0] TMR_TIMSK = 3'd4;

  localparam int TCCR_EN    = 4;
  localparam int TCCR_CTC   = 3;
  localparam int TIFR_OCF   = 1;
  localparam int TIFR_TOV   = 0;
  localparam int TIMSK_OCIE = 1;
  localparam int TIMSK_TOIE = 0;

  typedef enum logic [2:0] {
    CS_STOP    = 3'd0,
    CS_DIV1    = 3'd1,
    CS_DIV8    = 3'd2,
    CS_DIV64   = 3'd3,
    CS_DIV256  = 3'd4,
    CS_DIV1024 = 3'd5,
    CS_STOP6   = 3'd6,
    CS_STOP7   = 3'd7
  } tmr_cs_t;

  function automatic logic [9:0] cs_div_m1(input tmr_cs_t cs);
    case (cs)
      CS_DIV8:    return 10'd7;
      CS_DIV64:   return 10'd63;
      CS_DIV256:  return 10'd255;
      CS_DIV1024: return 10'd1023;
      default:    return 10'd0;
    endcase
  endfunction

  function automatic logic cs_runs(input tmr_cs_t cs);
    return (cs >= CS_DIV1) && (cs <= CS_DIV1024);
  endfunction

endpackage

// File: rtl/rp_8bit_tmr_psc.sv
// Free-running prescaler: counts to divisor-1 while enabled and emits a
// one-cycle tick as it wraps back to zero.
module rp_8bit_tmr_psc
  import rp_8bit_tmr_pkg::*;
#(
  parameter int PSW = 10
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    ena,
  input  logic    clr,
  input  tmr_cs_t cs,
  output logic    tick
);

  logic [PSW-1:0] r_cnt;
  logic [PSW-1:0] w_lim;

  assign w_lim = PSW'(cs_div_m1(cs));
  // tick reflects the count already reached, even when a clear arrives with it
  assign tick  = ena && (r_cnt == w_lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (ena) begin
      r_cnt <= tick ? '0 : r_cnt + PSW'(1);
    end
  end

endmodule

// File: rtl/rp_8bit_tmr.sv
// 8-bit timer/counter on the rp_8bit I/O bus: five-register window,
// registered OR-able read data and two level interrupt requests.
module rp_8bit_tmr
  import rp_8bit_tmr_pkg::*;
#(
  parameter logic [5:0] BAS = 6'h20,
  parameter int         PSW = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_wen,
  input  logic       io_ren,
  input  logic [5:0] io_adr,
  input  logic [7:0] io_wdt,
  input  logic [7:0] io_msk,
  output logic [7:0] io_rdt,
  output logic [1:0] irq_req,
  input  logic [1:0] irq_ack
);

  logic [7:0] r_tcnt;
  logic [7:0] r_ocr;
  logic [4:0] r_tccr;
  logic [1:0] r_tifr;
  logic [1:0] r_timsk;
  logic [7:0] r_rdt;

  logic [5:0] w_off_full;
  logic [2:0] w_off;
  logic       w_hit;
  logic       w_wr_tcnt, w_wr_ocr, w_wr_tccr, w_wr_tifr, w_wr_timsk;
  logic       w_tick;
  logic       w_psc_ena;
  logic       w_psc_clr;
  logic       w_cmp_eq;
  logic [1:0] w_set;
  logic [1:0] w_clr;
  logic [7:0] w_rdata;
  tmr_cs_t    w_cs;

  // Offset wraps for addresses below BAS, so one compare covers both sides
  assign w_off_full = io_adr - BAS;
  assign w_hit      = (w_off_full < 6'd5);
  assign w_off      = w_off_full[2:0];

  assign w_wr_tcnt  = io_wen && w_hit && (w_off == TMR_TCNT);
  assign w_wr_ocr   = io_wen && w_hit && (w_off == TMR_OCR);
  assign w_wr_tccr  = io_wen && w_hit && (w_off == TMR_TCCR);
  assign w_wr_tifr  = io_wen && w_hit && (w_off == TMR_TIFR);
  assign w_wr_timsk = io_wen && w_hit && (w_off == TMR_TIMSK);

  assign w_cs      = tmr_cs_t'(r_tccr[2:0]);
  assign w_psc_ena = r_tccr[TCCR_EN] && cs_runs(w_cs);
  assign w_psc_clr = w_wr_tccr || !r_tccr[TCCR_EN];

  rp_8bit_tmr_psc #(.PSW(PSW)) u_psc (
    .clk  (clk),
    .rst  (rst),
    .ena  (w_psc_ena),
    .clr  (w_psc_clr),
    .cs   (w_cs),
    .tick (w_tick)
  );

  // A CPU write to TCNT suppresses the tick's increment and flag evaluation
  assign w_cmp_eq           = (r_tcnt == r_ocr);
  assign w_set[TIFR_OCF]    = w_tick && !w_wr_tcnt && w_cmp_eq;
  assign w_set[TIFR_TOV]    = w_tick && !w_wr_tcnt && (r_tcnt == 8'hFF);
  assign w_clr              = ({2{w_wr_tifr}} & io_wdt[1:0] & io_msk[1:0]) | irq_ack;

  always_comb begin
    w_rdata = 8'h00;
    case (w_off)
      TMR_TCNT:  w_rdata = r_tcnt;
      TMR_OCR:   w_rdata = r_ocr;
      TMR_TCCR:  w_rdata = {3'b000, r_tccr};
      TMR_TIFR:  w_rdata = {6'b000000, r_tifr};
      TMR_TIMSK: w_rdata = {6'b000000, r_timsk};
      default:   w_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt  <= 8'h00;
      r_ocr   <= 8'hFF;
      r_tccr  <= 5'h00;
      r_tifr  <= 2'b00;
      r_timsk <= 2'b00;
      r_rdt   <= 8'h00;
    end else begin
      if (w_wr_tcnt) begin
        r_tcnt <= (io_wdt & io_msk) | (r_tcnt & ~io_msk);
      end else if (w_tick) begin
        r_tcnt <= (r_tccr[TCCR_CTC] && w_cmp_eq) ? 8'h00 : r_tcnt + 8'h01;
      end
      if (w_wr_ocr) begin
        r_ocr <= (io_wdt & io_msk) | (r_ocr & ~io_msk);
      end
      if (w_wr_tccr) begin
        r_tccr <= (io_wdt[4:0] & io_msk[4:0]) | (r_tccr & ~io_msk[4:0]);
      end
      if (w_wr_timsk) begin
        r_timsk <= (io_wdt[1:0] & io_msk[1:0]) | (r_timsk & ~io_msk[1:0]);
      end
      // hardware set wins over write-1-clear and acknowledge
      r_tifr <= w_set | (r_tifr & ~w_clr);
      r_rdt  <= (io_ren && w_hit) ? w_rdata : 8'h00;
    end
  end

  assign io_rdt               = r_rdt;
  assign irq_req[TIFR_TOV]    = r_tifr[TIFR_TOV] & r_timsk[TIMSK_TOIE];
  assign irq_req[TIFR_OCF]    = r_tifr[TIFR_OCF] & r_timsk[TIMSK_OCIE];

endmodule

// File: tb/tb_rp_8bit_tmr.sv
// Self-checking bench for rp_8bit_tmr: bus reads are scored against a queue
// of expected values pushed when each read is issued.
module tb_rp_8bit_tmr;

  localparam logic [5:0] A_TCNT  = 6'h20;
  localparam logic [5:0] A_OCR   = 6'h21;
  localparam logic [5:0] A_TCCR  = 6'h22;
  localparam logic [5:0] A_TIFR  = 6'h23;
  localparam logic [5:0] A_TIMSK = 6'h24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       io_wen = 1'b0;
  logic       io_ren = 1'b0;
  logic [5:0] io_adr = 6'h00;
  logic [7:0] io_wdt = 8'h00;
  logic [7:0] io_msk = 8'hFF;
  logic [7:0] io_rdt;
  logic [1:0] irq_req;
  logic [1:0] irq_ack = 2'b00;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] q_exp[$];
  string      q_nm[$];

  rp_8bit_tmr #(.BAS(6'h20), .PSW(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .io_wen  (io_wen),
    .io_ren  (io_ren),
    .io_adr  (io_adr),
    .io_wdt  (io_wdt),
    .io_msk  (io_msk),
    .io_rdt  (io_rdt),
    .irq_req (irq_req),
    .irq_ack (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d, input logic [7:0] m);
    io_wen = 1'b1;
    io_adr = a;
    io_wdt = d;
    io_msk = m;
    @(posedge clk);
    #1;
    io_wen = 1'b0;
    io_msk = 8'hFF;
  endtask

  task automatic score_pop();
    logic [7:0] exp;
    string nm;
    exp = q_exp.pop_front();
    nm  = q_nm.pop_front();
    n_chk++;
    if (io_rdt !== exp) begin
      n_err++;
      $display("FAIL %s: io_rdt=%h expected=%h", nm, io_rdt, exp);
    end
  endtask

  task automatic rd(input logic [5:0] a, input logic [7:0] exp, input string nm);
    io_ren = 1'b1;
    io_adr = a;
    q_exp.push_back(exp);
    q_nm.push_back(nm);
    @(posedge clk);
    #1;
    io_ren = 1'b0;
    score_pop();
  endtask

  task automatic test_reset();
    #23 rst = 1'b0;
    idle(1);
    n_chk++;
    if (irq_req !== 2'b00 || io_rdt !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: irq_req=%b io_rdt=%h expected=00/00", irq_req, io_rdt);
    end
    rd(A_TCNT,  8'h00, "rst_tcnt");
    rd(A_OCR,   8'hFF, "rst_ocr");
    rd(A_TCCR,  8'h00, "rst_tccr");
    rd(A_TIFR,  8'h00, "rst_tifr");
    rd(A_TIMSK, 8'h00, "rst_timsk");
    rd(A_OCR,   8'hFF, "rst_ocr2");
    idle(1);
    n_chk++;
    if (io_rdt !== 8'h00) begin
      n_err++;
      $display("FAIL no_ren_zero: io_rdt=%h expected=00", io_rdt);
    end
    rd(A_OCR,  8'hFF, "rst_ocr3");
    rd(6'h25,  8'h00, "miss_above");
    rd(A_OCR,  8'hFF, "rst_ocr4");
    rd(6'h1F,  8'h00, "miss_below");
  endtask

  task automatic test_masked_write();
    wr(A_TCNT, 8'hA5, 8'h0F);
    rd(A_TCNT, 8'h05, "mask_tcnt");
    wr(A_TIFR, 8'hFF, 8'hFF);
    rd(A_TIFR, 8'h00, "tifr_w1c_empty");
    wr(A_TIMSK, 8'hFF, 8'hFF);
    rd(A_TIMSK, 8'h03, "timsk_reserved");
    wr(A_TCCR, 8'hFF, 8'hFF);
    rd(A_TCCR, 8'h1F, "tccr_reserved");
    wr(A_TCCR, 8'h00, 8'hFF);
    wr(A_TIMSK, 8'h00, 8'hFF);
    rd(A_TCNT, 8'h05, "tcnt_cs7_frozen");
  endtask

  task automatic test_rw_same_cycle();
    wr(A_OCR, 8'hFF, 8'hFF);
    io_wen = 1'b1;
    io_ren = 1'b1;
    io_adr = A_OCR;
    io_wdt = 8'h55;
    io_msk = 8'hFF;
    q_exp.push_back(8'hFF);
    q_nm.push_back("rw_pre_write");
    @(posedge clk);
    #1;
    io_wen = 1'b0;
    io_ren = 1'b0;
    score_pop();
    rd(A_OCR, 8'h55, "rw_post_write");
  endtask

  task automatic test_free_run();
    wr(A_TIMSK, 8'h01, 8'hFF);
    wr(A_TCNT,  8'hFD, 8'hFF);
    wr(A_TCCR,  8'h11, 8'hFF);
    idle(3);
    n_chk++;
    if (irq_req !== 2'b01) begin
      n_err++;
      $display("FAIL free_run_irq: irq_req=%b expected=01", irq_req);
    end
    rd(A_TCNT, 8'h00, "free_run_wrap");
    rd(A_TIFR, 8'h01, "free_run_tov");
    wr(A_TCCR, 8'h00, 8'hFF);
    irq_ack = 2'b01;
    @(posedge clk);
    #1;
    irq_ack = 2'b00;
    n_chk++;
    if (irq_req !== 2'b00) begin
      n_err++;
      $display("FAIL ack_irq: irq_req=%b expected=00", irq_req);
    end
    rd(A_TIFR, 8'h00, "ack_tov_clear");
  endtask

  task automatic test_ctc();
    logic [7:0] seq [6];
    seq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    wr(A_TCNT,  8'h00, 8'hFF);
    wr(A_TIFR,  8'hFF, 8'hFF);
    wr(A_OCR,   8'h04, 8'hFF);
    wr(A_TIMSK, 8'h02, 8'hFF);
    wr(A_TCCR,  8'h1A, 8'hFF);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (irq_req !== ((k == 40) ? 2'b10 : 2'b00)) begin
        n_err++;
        $display("FAIL ctc_ocf_timing: cycle %0d irq_req=%b expected=%b",
                 k, irq_req, (k == 40) ? 2'b10 : 2'b00);
      end
    end
    rd(A_TCNT, seq[0], "ctc_seq0");
    for (int i = 1; i < 6; i++) begin
      idle(7);
      rd(A_TCNT, seq[i], "ctc_seq");
    end
    rd(A_TIFR, 8'h02, "ctc_no_tov");
    n_chk++;
    if (irq_req !== 2'b10) begin
      n_err++;
      $display("FAIL ctc_irq: irq_req=%b expected=10", irq_req);
    end
    wr(A_TCCR, 8'h00, 8'hFF);
  endtask

  task automatic test_collisions();
    wr(A_TCNT, 8'h00, 8'hFF);
    wr(A_OCR,  8'h03, 8'hFF);
    wr(A_TIFR, 8'hFF, 8'hFF);
    wr(A_TCCR, 8'h19, 8'hFF);
    idle(4);
    n_chk++;
    if (irq_req !== 2'b10) begin
      n_err++;
      $display("FAIL coll_ocf_set: irq_req=%b expected=10", irq_req);
    end
    wr(A_TIFR, 8'h02, 8'hFF);
    n_chk++;
    if (irq_req !== 2'b00) begin
      n_err++;
      $display("FAIL coll_w1c: irq_req=%b expected=00", irq_req);
    end
    idle(2);
    wr(A_TIFR, 8'h02, 8'hFF);
    rd(A_TIFR, 8'h02, "coll_set_beats_clear");
    wr(A_TCCR, 8'h11, 8'hFF);
    wr(A_TCNT, 8'h10, 8'hFF);
    rd(A_TCNT, 8'h10, "coll_write_wins");
    wr(A_TCCR, 8'h00, 8'hFF);
  endtask

  task automatic test_stop();
    wr(A_TCNT, 8'h42, 8'hFF);
    wr(A_TCCR, 8'h16, 8'hFF);
    idle(2000);
    rd(A_TCNT, 8'h42, "stop_cs6");
    wr(A_TCCR, 8'h00, 8'hFF);
  endtask

  task automatic test_async_reset();
    wr(A_TIFR,  8'hFF, 8'hFF);
    wr(A_TIMSK, 8'h01, 8'hFF);
    wr(A_TCNT,  8'hFF, 8'hFF);
    wr(A_TCCR,  8'h11, 8'hFF);
    wr(A_TCCR,  8'h15, 8'hFF);
    n_chk++;
    if (irq_req !== 2'b01) begin
      n_err++;
      $display("FAIL pre_reset_irq: irq_req=%b expected=01", irq_req);
    end
    wr(A_OCR, 8'h55, 8'hFF);
    rd(A_OCR, 8'h55, "pre_reset_ocr");
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (irq_req !== 2'b00 || io_rdt !== 8'h00) begin
      n_err++;
      $display("FAIL async_reset: irq_req=%b io_rdt=%h expected=00/00", irq_req, io_rdt);
    end
    idle(2);
    #2 rst = 1'b0;
    idle(1);
    rd(A_TCNT, 8'h00, "post_reset_tcnt");
    rd(A_TCCR, 8'h00, "post_reset_tccr");
    rd(A_OCR,  8'hFF, "post_reset_ocr");
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_rw_same_cycle();
    test_free_run();
    test_ctc();
    test_collisions();
    test_stop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
